// File: rtl/quant_stream_applier.sv
// rtl/quant_stream_applier.sv - int8 requantizer for a signed accumulator stream, scaled by a latched Q8.24 factor
//
// Latches reciprocal_scale on a scale_ready pulse. It then quantizes one tensor of
// signed samples to q = sat(round(x * scale / 2^FRAC_BITS)) through a three-stage
// valid/ready pipeline. Saturation is symmetric, to [-127, 127].
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   scale_ready, reciprocal_scale  scale handshake (sampled only while idle)
//   in_valid/in_ready/in_data/in_last      input stream
//   out_valid/out_ready/out_data/out_last  output stream
//   busy                        block holds a scale and is processing a tensor
//   sat_count                   clipped-output counter
//
// Optional feature macro: QUANT_SAT_COUNT_EN. When it is defined, sat_count counts
// clipped output handshakes. When it is undefined, sat_count is tied to zero.
module quant_stream_applier #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 24,
    parameter int SCALE_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scale_ready,
    input  logic [SCALE_W-1:0] reciprocal_scale,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic [15:0]        sat_count
);

    localparam int PROD_W = IN_W + SCALE_W + 1;
    localparam logic signed [PROD_W:0] HALF = (PROD_W+1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [PROD_W:0] QMAX = (PROD_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PROD_W:0] QMIN = -QMAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [SCALE_W-1:0]   scale;

    logic                 advance;
    logic                 accept;
    logic                 out_fire;

    logic                 s1_valid;
    logic                 s1_last;
    logic signed [IN_W-1:0]   s1_data;
    logic                 s2_valid;
    logic                 s2_last;
    logic signed [PROD_W-1:0] s2_prod;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W:0]   biased;
    logic signed [PROD_W:0]   shifted;
    logic [OUT_W-1:0]         q;

    // The whole pipeline moves together whenever the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == RUN) && advance;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != IDLE);

    // A zero-extended scale keeps the multiply signed without treating scale bit 31 as a sign.
    assign prod    = s1_data * $signed({1'b0, scale});
    assign biased  = $signed({s2_prod[PROD_W-1], s2_prod}) + HALF;
    assign shifted = biased >>> FRAC_BITS;

    always_comb begin
        q = shifted[OUT_W-1:0];
        if (shifted > QMAX) begin
            q = QMAX[OUT_W-1:0];
        end else if (shifted < QMIN) begin
            q = QMIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            scale <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scale_ready) begin
                        scale <= reciprocal_scale;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_data   <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_prod   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= accept;
            s1_last   <= accept && in_last;
            s1_data   <= in_data;
            s2_valid  <= s1_valid;
            s2_last   <= s1_valid && s1_last;
            s2_prod   <= prod;
            out_valid <= s2_valid;
            out_last  <= s2_valid && s2_last;
            out_data  <= q;
        end
    end

`ifdef QUANT_SAT_COUNT_EN
    logic clip;
    logic out_sat;

    assign clip = (shifted > QMAX) || (shifted < QMIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_sat <= 1'b0;
        end else if (advance) begin
            out_sat <= s2_valid && clip;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (state == IDLE && scale_ready) begin
            sat_count <= '0;
        end else if (out_fire && out_sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule
